// File: rtl/aurora_adc_frame_parser_pkg.sv
// Shared types and derived-size helpers for the Aurora ADC frame parser.
// Frame layout: beat 0 carries header A, beat N carries header B in its high half.
package aurora_parser_pkg;

  typedef enum logic {
    ALIGNED = 1'b0,
    HUNT    = 1'b1
  } parser_state_e;

  // Minimum of 1 so an index never collapses to a zero-width vector.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int frame_beats(input int n);
    return 2 * n + 1;
  endfunction

  function automatic int adc_per_frame(input int n);
    return 2 * n;
  endfunction

  localparam int ADC_PER_SUB_DEF = 4;
  localparam int FRAME_BEATS     = frame_beats(ADC_PER_SUB_DEF);
  localparam int ADC_PER_FRAME   = adc_per_frame(ADC_PER_SUB_DEF);

endpackage

// File: rtl/aurora_adc_frame_parser_if.sv
// Stream-in / parsed-words-out bundle for the Aurora ADC frame parser.
// slave = parser side, master = source/sink side.
interface aurora_adc_frame_parser_if
  import aurora_parser_pkg::*;
#(
  parameter int DATA_WD = 128,
  parameter int HEAD_WD = DATA_WD / 2,
  parameter int IDX_WD  = clog2(ADC_PER_FRAME),
  parameter int CNT_WD  = 16
);
  logic [DATA_WD-1:0]   s_axis_tdata;
  logic [DATA_WD/8-1:0] s_axis_tkeep;
  logic                 s_axis_tvalid;
  logic                 s_axis_tlast;

  logic                 head_vld;
  logic [HEAD_WD-1:0]   head_data;
  logic                 head_idx;
  logic                 adc_vld;
  logic [DATA_WD-1:0]   adc_data;
  logic [IDX_WD-1:0]    adc_idx;
  logic                 adc_last;
  logic                 frame_err;
  logic [CNT_WD-1:0]    err_cnt;
  logic [CNT_WD-1:0]    frame_cnt;
  logic                 locked;

  modport slave (
    input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
    output head_vld, head_data, head_idx, adc_vld, adc_data, adc_idx,
           adc_last, frame_err, err_cnt, frame_cnt, locked
  );

  modport master (
    output s_axis_tdata, s_axis_tkeep, s_axis_tvalid, s_axis_tlast,
    input  head_vld, head_data, head_idx, adc_vld, adc_data, adc_idx,
           adc_last, frame_err, err_cnt, frame_cnt, locked
  );
endinterface

// File: rtl/aurora_adc_frame_parser_sat_counter.sv
// Event counter with synchronous clear; SATURATE selects stick-at-max vs wrap.
module aurora_sat_counter #(
  parameter int WD       = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [WD-1:0] cnt
);
  logic [WD-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else if (clr)
      cnt_q <= '0;
    else if (inc && !(SATURATE && (&cnt_q)))
      cnt_q <= cnt_q + 1'b1;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/aurora_adc_frame_parser.sv
// Splits a 2N+1 beat Aurora frame into two half-width headers and 2N ADC words,
// checking tlast/tkeep framing and re-locking on tlast after an error.
module aurora_adc_frame_parser
  import aurora_parser_pkg::*;
#(
  parameter int DATA_WD       = 128,
  parameter int HEAD_WD       = DATA_WD / 2,
  parameter int ADC_PER_SUB   = ADC_PER_SUB_DEF,
  parameter bit CHECK_FRAMING = 1'b1,
  parameter bit RESYNC_EN     = 1'b1,
  parameter int ERR_CNT_WD    = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic cfg_rst,
  aurora_adc_frame_parser_if.slave bus
);
  localparam int N_ADC   = adc_per_frame(ADC_PER_SUB);
  localparam int K_WD    = clog2(frame_beats(ADC_PER_SUB));
  localparam int IDX_WD  = clog2(N_ADC);
  localparam int KEEP_WD = DATA_WD / 8;
  localparam logic [K_WD-1:0] K_HDRB = K_WD'(ADC_PER_SUB);
  localparam logic [K_WD-1:0] K_LAST = K_WD'(N_ADC);

  parser_state_e       state;
  logic [K_WD-1:0]     k;
  logic [DATA_WD-1:0]  d1;
  logic                beat, aligned, at_last, err_beat, good, frame_inc;
  logic [K_WD-1:0]     k_nxt;
  logic [ERR_CNT_WD-1:0] err_cnt, frame_cnt;

  always_comb begin
    beat      = bus.s_axis_tvalid & ~cfg_rst;   // clear beats a concurrent beat
    aligned   = (state == ALIGNED);
    at_last   = (k == K_LAST);
    err_beat  = 1'b0;
    if (CHECK_FRAMING)
      err_beat = beat & aligned &
                 ((bus.s_axis_tlast != at_last) | (bus.s_axis_tkeep != {KEEP_WD{1'b1}}));
    good      = beat & aligned & ~err_beat;
    frame_inc = good & at_last;
    k_nxt     = at_last ? '0 : k + K_WD'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ALIGNED;
      k             <= '0;
      d1            <= '0;
      bus.head_vld  <= 1'b0;
      bus.head_data <= '0;
      bus.head_idx  <= 1'b0;
      bus.adc_vld   <= 1'b0;
      bus.adc_data  <= '0;
      bus.adc_idx   <= '0;
      bus.adc_last  <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.locked    <= 1'b1;
    end else if (cfg_rst) begin
      state         <= ALIGNED;
      k             <= '0;
      d1            <= '0;
      bus.head_vld  <= 1'b0;
      bus.head_data <= '0;
      bus.head_idx  <= 1'b0;
      bus.adc_vld   <= 1'b0;
      bus.adc_data  <= '0;
      bus.adc_idx   <= '0;
      bus.adc_last  <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.locked    <= 1'b1;
    end else begin
      bus.head_vld  <= 1'b0;
      bus.adc_vld   <= 1'b0;
      bus.adc_last  <= 1'b0;
      bus.frame_err <= err_beat;
      if (beat) begin
        d1 <= bus.s_axis_tdata;
        if (!aligned) begin
          // the tlast that ends the hunt is consumed, next beat is header A
          if (bus.s_axis_tlast) begin
            state      <= ALIGNED;
            k          <= '0;
            bus.locked <= 1'b1;
          end
        end else if (err_beat && RESYNC_EN) begin
          state      <= HUNT;
          k          <= '0;
          bus.locked <= 1'b0;
        end else begin
          k <= k_nxt;
        end
      end
      if (good) begin
        if (k == '0) begin
          bus.head_vld  <= 1'b1;
          bus.head_idx  <= 1'b0;
          bus.head_data <= bus.s_axis_tdata[HEAD_WD-1:0];
        end
        if (k == K_HDRB) begin
          bus.head_vld  <= 1'b1;
          bus.head_idx  <= 1'b1;
          bus.head_data <= bus.s_axis_tdata[DATA_WD-1:HEAD_WD];
        end
        if (k != '0) begin
          // first sub-frame words straddle beats by half a word
          bus.adc_vld  <= 1'b1;
          bus.adc_idx  <= IDX_WD'(k - K_WD'(1));
          bus.adc_data <= (k <= K_HDRB) ?
                          {bus.s_axis_tdata[HEAD_WD-1:0], d1[DATA_WD-1:HEAD_WD]} :
                          bus.s_axis_tdata;
          bus.adc_last <= at_last;
        end
      end
    end
  end

  aurora_sat_counter #(.WD(ERR_CNT_WD), .SATURATE(1'b1)) u_err_cnt (
    .clk (clk), .rst (rst), .clr (cfg_rst), .inc (err_beat), .cnt (err_cnt)
  );

  aurora_sat_counter #(.WD(ERR_CNT_WD), .SATURATE(1'b0)) u_frame_cnt (
    .clk (clk), .rst (rst), .clr (cfg_rst), .inc (frame_inc), .cnt (frame_cnt)
  );

  assign bus.err_cnt   = err_cnt;
  assign bus.frame_cnt = frame_cnt;
endmodule

// File: tb/tb_aurora_adc_frame_parser.sv
// Random-stimulus scoreboard bench: one parser re-locks on errors, its twin keeps counting.
module tb_aurora_adc_frame_parser;
  localparam int N  = 4;
  localparam int NB = 2 * N + 1;
  localparam int DW = 128;
  localparam int HW = 64;
  localparam int IW = 3;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_rst = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0]   s_tdata = '0;
  logic [DW/8-1:0] s_tkeep = '0;
  logic            s_tvalid = 1'b0;
  logic            s_tlast = 1'b0;

  aurora_adc_frame_parser_if #(.DATA_WD(DW), .HEAD_WD(HW), .IDX_WD(IW), .CNT_WD(CW)) bus_a ();
  aurora_adc_frame_parser_if #(.DATA_WD(DW), .HEAD_WD(HW), .IDX_WD(IW), .CNT_WD(CW)) bus_b ();

  assign bus_a.s_axis_tdata = s_tdata;   assign bus_b.s_axis_tdata = s_tdata;
  assign bus_a.s_axis_tkeep = s_tkeep;   assign bus_b.s_axis_tkeep = s_tkeep;
  assign bus_a.s_axis_tvalid = s_tvalid; assign bus_b.s_axis_tvalid = s_tvalid;
  assign bus_a.s_axis_tlast = s_tlast;   assign bus_b.s_axis_tlast = s_tlast;

  aurora_adc_frame_parser #(.DATA_WD(DW), .HEAD_WD(HW), .ADC_PER_SUB(N), .CHECK_FRAMING(1'b1),
    .RESYNC_EN(1'b1), .ERR_CNT_WD(CW)) dut_a (.clk(clk), .rst(rst), .cfg_rst(cfg_rst), .bus(bus_a));
  aurora_adc_frame_parser #(.DATA_WD(DW), .HEAD_WD(HW), .ADC_PER_SUB(N), .CHECK_FRAMING(1'b1),
    .RESYNC_EN(1'b0), .ERR_CNT_WD(CW)) dut_b (.clk(clk), .rst(rst), .cfg_rst(cfg_rst), .bus(bus_b));

  typedef struct packed {
    logic          head_vld;
    logic          head_idx;
    logic [HW-1:0] head_data;
    logic          adc_vld;
    logic [IW-1:0] adc_idx;
    logic [DW-1:0] adc_data;
    logic          adc_last;
    logic          frame_err;
    logic [CW-1:0] err_cnt;
    logic [CW-1:0] frame_cnt;
    logic          locked;
  } out_t;

  out_t act [2];
  assign act[0] = {bus_a.head_vld, bus_a.head_idx, bus_a.head_data, bus_a.adc_vld, bus_a.adc_idx,
                   bus_a.adc_data, bus_a.adc_last, bus_a.frame_err, bus_a.err_cnt, bus_a.frame_cnt,
                   bus_a.locked};
  assign act[1] = {bus_b.head_vld, bus_b.head_idx, bus_b.head_data, bus_b.adc_vld, bus_b.adc_idx,
                   bus_b.adc_data, bus_b.adc_last, bus_b.frame_err, bus_b.err_cnt, bus_b.frame_cnt,
                   bus_b.locked};

  // Reference model, index 0 = re-locking parser, 1 = free-counting parser
  bit            m_hunt [2];
  int            m_k [2];
  logic [DW-1:0] m_prev [2];
  logic [CW-1:0] m_err [2];
  logic [CW-1:0] m_frm [2];
  logic          m_locked [2];
  out_t          exp_q [2][$];

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [DW-1:0] a, input logic [DW-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    for (int v = 0; v < 2; v++) begin
      m_hunt[v] = 0; m_k[v] = 0; m_prev[v] = '0;
      m_err[v] = '0; m_frm[v] = '0; m_locked[v] = 1'b1;
    end
  endtask

  // One accepted beat: decide its role from its position in the frame.
  task automatic model_beat(input int v, input logic [DW-1:0] d, input logic [DW/8-1:0] kp,
                            input logic lst);
    out_t e;
    bit broken;
    e = '0;
    if (m_hunt[v]) begin
      if (lst) begin m_hunt[v] = 0; m_k[v] = 0; m_locked[v] = 1'b1; end
      m_prev[v] = d;
      return;
    end
    broken = (lst != (m_k[v] == 2 * N)) || (kp != '1);
    if (broken) begin
      e.frame_err = 1'b1;
      if (m_err[v] != '1) m_err[v] = m_err[v] + 1'b1;
      if (v == 0) begin m_hunt[v] = 1; m_locked[v] = 1'b0; end
      else m_k[v] = (m_k[v] + 1) % NB;
    end else begin
      if (m_k[v] == 0) begin e.head_vld = 1'b1; e.head_idx = 1'b0; e.head_data = d[HW-1:0]; end
      if (m_k[v] == N) begin e.head_vld = 1'b1; e.head_idx = 1'b1; e.head_data = d[DW-1:HW]; end
      if (m_k[v] >= 1) begin
        e.adc_vld  = 1'b1;
        e.adc_idx  = IW'(m_k[v] - 1);
        e.adc_data = (m_k[v] <= N) ? {d[HW-1:0], m_prev[v][DW-1:HW]} : d;
      end
      if (m_k[v] == 2 * N) begin e.adc_last = 1'b1; m_frm[v] = m_frm[v] + 1'b1; end
      m_k[v] = (m_k[v] + 1) % NB;
    end
    m_prev[v] = d;
    e.err_cnt = m_err[v]; e.frame_cnt = m_frm[v]; e.locked = m_locked[v];
    exp_q[v].push_back(e);
  endtask

  // Monitor: every strobe the DUT raises must match the oldest expected record.
  initial begin : monitor
    out_t e;
    forever begin
      @(negedge clk);
      for (int v = 0; v < 2; v++) begin
        if (act[v].head_vld || act[v].adc_vld || act[v].frame_err) begin
          total++;
          if (exp_q[v].size() == 0) begin
            bad++;
            $display("FAIL unexpected_out v%0d: got strobe, expected none", v);
          end else begin
            e = exp_q[v].pop_front();
            chk($sformatf("v%0d head_vld", v), act[v].head_vld, e.head_vld);
            if (e.head_vld) begin
              chk($sformatf("v%0d head_idx", v), act[v].head_idx, e.head_idx);
              chk($sformatf("v%0d head_data", v), act[v].head_data, e.head_data);
            end
            chk($sformatf("v%0d adc_vld", v), act[v].adc_vld, e.adc_vld);
            if (e.adc_vld) begin
              chk($sformatf("v%0d adc_idx", v), act[v].adc_idx, e.adc_idx);
              chk($sformatf("v%0d adc_data", v), act[v].adc_data, e.adc_data);
              chk($sformatf("v%0d adc_last", v), act[v].adc_last, e.adc_last);
            end
            chk($sformatf("v%0d frame_err", v), act[v].frame_err, e.frame_err);
            chk($sformatf("v%0d err_cnt", v), act[v].err_cnt, e.err_cnt);
            chk($sformatf("v%0d frame_cnt", v), act[v].frame_cnt, e.frame_cnt);
            chk($sformatf("v%0d locked", v), act[v].locked, e.locked);
          end
        end
      end
    end
  end

  // Called at posedge+1 with tvalid low; returns at posedge+1 after the beat.
  task automatic send_beat(input logic [DW-1:0] d, input logic [DW/8-1:0] kp, input logic lst,
                           input int gap);
    repeat (gap) begin @(posedge clk); #1; end
    s_tdata = d; s_tkeep = kp; s_tlast = lst; s_tvalid = 1'b1;
    model_beat(0, d, kp, lst);
    model_beat(1, d, kp, lst);
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  // trunc_at: early tlast on that beat; badkeep_at: tkeep hole; stop_at: end without tlast.
  task automatic send_frame(input int gapmax, input int trunc_at, input int badkeep_at,
                            input int stop_at);
    for (int b = 0; b < NB; b++) begin
      send_beat(rnd128(), (b == badkeep_at) ? 16'h7FFF : 16'hFFFF,
                (b == NB - 1) || (b == trunc_at), $urandom_range(0, gapmax));
      if (b == trunc_at || b == stop_at) break;
    end
  endtask

  task automatic chk_state(input string tag);
    @(negedge clk);
    for (int v = 0; v < 2; v++) begin
      chk($sformatf("%s v%0d locked", tag, v), act[v].locked, m_locked[v]);
      chk($sformatf("%s v%0d err_cnt", tag, v), act[v].err_cnt, m_err[v]);
      chk($sformatf("%s v%0d frame_cnt", tag, v), act[v].frame_cnt, m_frm[v]);
      chk($sformatf("%s v%0d drained", tag, v), exp_q[v].size(), 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_cleared(input string tag);
    for (int v = 0; v < 2; v++) begin
      chk($sformatf("%s v%0d head_vld", tag, v), act[v].head_vld, 1'b0);
      chk($sformatf("%s v%0d adc_vld", tag, v), act[v].adc_vld, 1'b0);
      chk($sformatf("%s v%0d frame_err", tag, v), act[v].frame_err, 1'b0);
      chk($sformatf("%s v%0d head_data", tag, v), act[v].head_data, '0);
      chk($sformatf("%s v%0d adc_data", tag, v), act[v].adc_data, '0);
      chk($sformatf("%s v%0d err_cnt", tag, v), act[v].err_cnt, '0);
      chk($sformatf("%s v%0d frame_cnt", tag, v), act[v].frame_cnt, '0);
      chk($sformatf("%s v%0d locked", tag, v), act[v].locked, 1'b1);
    end
  endtask

  task automatic soft_clear();
    cfg_rst = 1'b1;
    @(posedge clk); #1;
    cfg_rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_cleared("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    for (int f = 0; f < 3; f++) send_frame(0, -1, -1, -1);
    chk_state("b2b");
    for (int f = 0; f < 3; f++) send_frame(5, -1, -1, -1);
    chk_state("gaps");

    soft_clear();
    send_frame(0, 5, -1, -1);
    chk_state("tlast5");
    send_frame(2, -1, -1, -1);
    chk_state("relock");
    send_frame(0, -1, -1, -1);
    chk_state("after_relock");

    soft_clear();
    send_frame(1, -1, 2, -1);
    chk_state("tkeep2");

    soft_clear();
    for (int f = 0; f < 8; f++)
      for (int b = 0; b < NB; b++)
        send_beat(rnd128(),
                  ($urandom_range(0, 15) == 0) ? (16'hFFFF ^ (16'h1 << $urandom_range(0, 15))) : 16'hFFFF,
                  (b == NB - 1) ^ ($urandom_range(0, 15) == 0), $urandom_range(0, 3));
    chk_state("random");

    soft_clear();
    force dut_a.u_err_cnt.cnt_q = 16'hFFFE;
    force dut_b.u_err_cnt.cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut_a.u_err_cnt.cnt_q;
    release dut_b.u_err_cnt.cnt_q;
    m_err[0] = 16'hFFFE; m_err[1] = 16'hFFFE;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++)
      send_beat(rnd128(), (i % 2 == 0) ? 16'h7FFF : 16'hFFFF, i % 2 == 1, 0);
    chk_state("saturate");
    chk("sat v0 err_cnt max", act[0].err_cnt, 16'hFFFF);

    soft_clear();
    send_frame(0, -1, -1, 3);
    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk_cleared("async_rst");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    send_frame(0, -1, -1, -1);
    chk_state("post_rst");

    s_tdata = rnd128(); s_tkeep = 16'hFFFF; s_tlast = 1'b1; s_tvalid = 1'b1; cfg_rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0; cfg_rst = 1'b0;
    chk_cleared("cfg_rst_beat");
    send_frame(0, -1, -1, -1);
    chk_state("post_cfg_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
